sss_re_mapper: RTL and testbench

Downstream stage of the SSS generator.
- Captures the 62-bit SSS bit vector on a start strobe.
- BPSK-modulates each bit and streams the result as one I/Q sample per subcarrier over a valid/ready interface.
- Adds 5 zero-guard subcarriers on each side, giving a 72-subcarrier (6 RB) burst to the IFFT/resource-grid writer.

---
 rtl/sss_re_mapper_if.sv | 22 ++
 rtl/sss_re_mapper.sv | 115 +++++++++++
 tb/tb_sss_re_mapper.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sss_re_mapper_if.sv
// Streaming I/Q sample bus from the SSS resource-element mapper to the grid writer.
// Carries one BPSK sample per subcarrier; the master drives data, the slave drives ready.
interface sss_re_mapper_if #(
    parameter int IQ_W = 16
);
    logic                   m_valid;
    logic                   m_ready;
    logic signed [IQ_W-1:0] m_i;
    logic signed [IQ_W-1:0] m_q;
    logic [6:0]             m_sc_idx;
    logic                   m_last;

    modport master (
        output m_valid, m_i, m_q, m_sc_idx, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_i, m_q, m_sc_idx, m_last,
        output m_ready
    );
endinterface

// File: rtl/sss_re_mapper.sv
// SSS resource-element mapper: latches the 62 SSS bits and streams a guarded BPSK burst.
// Define SSS_DC_INSERT_EN to insert a DC zero after data subcarrier 30 (73-sample burst).
module sss_re_mapper #(
    parameter int IQ_W  = 16,
    parameter int AMP   = 11585,
    parameter int GUARD = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [61:0]          sss_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    sss_re_mapper_if.master      m
);
`ifdef SSS_DC_INSERT_EN
    localparam int DC_EN = 1;
`else
    localparam int DC_EN = 0;
`endif
    localparam int DATA_N   = 62 + DC_EN;
    localparam int DC_IDX   = GUARD + 31;
    localparam int LAST_IDX = 2 * GUARD + DATA_N - 1;

    typedef enum logic [1:0] {IDLE, LEAD, DATA, TRAIL} state_t;

    state_t      state, state_nxt;
    logic [6:0]  sc_cnt;
    logic [61:0] shadow;
    logic        hs;
    logic        accept;
    logic        at_last;
    logic        is_dc;

    function automatic logic signed [IQ_W-1:0] bpsk_map(input logic b);
        logic signed [IQ_W-1:0] amp;
        amp = IQ_W'(AMP);
        return b ? -amp : amp;
    endfunction

    // Subcarrier index to SSS bit; subcarriers past the DC slot shift down by one.
    function automatic logic data_bit(input logic [61:0] v, input logic [6:0] idx);
        logic [6:0] k;
        k = idx - 7'(GUARD);
        if (DC_EN != 0 && idx > 7'(DC_IDX)) begin
            k = k - 7'd1;
        end
        return v[k[5:0]];
    endfunction

    assign accept     = (state == IDLE) && start;
    assign hs         = m.m_valid && m.m_ready;
    assign at_last    = (sc_cnt == 7'(LAST_IDX));
    assign is_dc      = (DC_EN != 0) && (sc_cnt == 7'(DC_IDX));
    assign m.m_sc_idx = sc_cnt;
    assign m.m_q      = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LEAD;
            LEAD:    if (hs && sc_cnt == 7'(GUARD - 1)) state_nxt = DATA;
            DATA:    if (hs && sc_cnt == 7'(GUARD + DATA_N - 1)) state_nxt = TRAIL;
            TRAIL:   if (hs && at_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m.m_valid = 1'b0;
        m.m_i     = '0;
        m.m_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            LEAD, TRAIL: begin
                m.m_valid = 1'b1;
                busy      = 1'b1;
                m.m_last  = (state == TRAIL) && at_last;
            end
            DATA: begin
                m.m_valid = 1'b1;
                busy      = 1'b1;
                if (!is_dc) begin
                    m.m_i = bpsk_map(data_bit(shadow, sc_cnt));
                end
            end
            default: ;
        endcase
    end

    // Counter only moves on a handshake, so a stalled sample holds all its fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            sc_cnt <= '0;
            shadow <= '0;
            done   <= 1'b0;
        end else begin
            done <= hs && at_last && (state == TRAIL);
            if (accept) begin
                shadow <= sss_in;
                sc_cnt <= '0;
            end else if (hs) begin
                sc_cnt <= at_last ? 7'd0 : sc_cnt + 7'd1;
            end
        end
    end
endmodule

// File: tb/tb_sss_re_mapper.sv
// Directed/randomized bench for sss_re_mapper against a burst-level expected-sample list.
module tb_sss_re_mapper;
`ifdef SSS_DC_INSERT_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif
    localparam int N   = DC ? 73 : 72;
    localparam int AMP = 11585;

    logic        clk;
    logic        reset;
    logic [61:0] sss_in;
    logic        start;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    sss_re_mapper_if #(.IQ_W(16)) mif ();

    sss_re_mapper #(.IQ_W(16), .AMP(AMP), .GUARD(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .sss_in (sss_in),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .m      (mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Expected burst: guard zeros, BPSK data (optional DC zero after bit 30), guard zeros.
    task automatic build_ref(input logic [61:0] v);
        exp_q.delete();
        repeat (5) exp_q.push_back(0);
        for (int k = 0; k < 62; k++) begin
            if (DC && k == 31) exp_q.push_back(0);
            exp_q.push_back(v[k] ? -AMP : AMP);
        end
        repeat (5) exp_q.push_back(0);
    endtask

    function automatic logic [61:0] rnd62();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[61:0];
    endfunction

    task automatic run_burst(input logic [61:0] vec, input bit pre, input int stall_at,
                             input int stall_len, input int restart_at, input int reset_at,
                             input bit chg, input bit b2b, input logic [61:0] next_vec);
        int cyc;
        int e;
        int stalled;
        bit fin;
        build_ref(vec);
        if (!pre) begin
            sss_in = vec;
            start  = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        if (chg) sss_in = '1;
        e = 0;
        fin = 1'b0;
        stalled = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            chk("valid", mif.m_valid, 1);
            chk("sc_idx", mif.m_sc_idx, e);
            chk("m_i", mif.m_i, exp_q[e]);
            chk("m_q", mif.m_q, 0);
            chk("last", mif.m_last, (e == N - 1));
            chk("busy", busy, 1);
            chk("done_mid", done, 0);
            if (e == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("rst_valid", mif.m_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_idx", mif.m_sc_idx, 0);
                @(posedge clk); #1;
                chk("rst_no_done", done, 0);
                return;
            end
            if (e == stall_at) begin
                mif.m_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    @(posedge clk); #1;
                    cyc++;
                    stalled++;
                    chk("stall_valid", mif.m_valid, 1);
                    chk("stall_idx", mif.m_sc_idx, e);
                    chk("stall_m_i", mif.m_i, exp_q[e]);
                    chk("stall_last", mif.m_last, (e == N - 1));
                end
                mif.m_ready = 1'b1;
            end
            if (e == restart_at) start = 1'b1;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (e == N - 1) fin = 1'b1;
            else e++;
        end
        if (!fin) begin
            chk("timeout", 0, 1);
        end else begin
            chk("done", done, 1);
            chk("busy_end", busy, 0);
            chk("valid_end", mif.m_valid, 0);
            chk("latency", cyc, N + 1 + stalled);
            if (b2b) begin
                sss_in = next_vec;
                start  = 1'b1;
            end else begin
                @(posedge clk); #1;
                chk("done_width", done, 0);
            end
        end
    endtask

    initial begin
        logic [61:0] r1;
        logic [61:0] r2;
        logic [61:0] r3;
        reset       = 1'b1;
        start       = 1'b0;
        sss_in      = '0;
        mif.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid0", mif.m_valid, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_idx0", mif.m_sc_idx, 0);
        chk("rst_last0", mif.m_last, 0);
        chk("rst_m_i0", mif.m_i, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_burst(62'h0, 0, -1, 0, -1, -1, 0, 0, 62'h0);
        run_burst(62'h1, 0, -1, 0, -1, -1, 0, 0, 62'h0);
        run_burst(62'h2000_0000_0000_0000, 0, -1, 0, -1, -1, 0, 0, 62'h0);
        run_burst('1, 0, -1, 0, -1, -1, 0, 0, 62'h0);

        r1 = rnd62();
        run_burst(r1, 0, 10, 3, -1, -1, 0, 0, 62'h0);

        r2 = rnd62();
        r3 = rnd62();
        run_burst(r2, 0, -1, 0, 20, -1, 1, 1, r3);
        run_burst(r3, 1, -1, 0, -1, -1, 0, 0, 62'h0);

        r1 = rnd62();
        run_burst(r1, 0, -1, 0, -1, 40, 0, 0, 62'h0);
        r2 = rnd62();
        run_burst(r2, 0, -1, 0, -1, -1, 0, 0, 62'h0);

        r3 = rnd62();
        run_burst(r3, 0, int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)), -1, -1, 0, 0, 62'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
